// File: rtl/pdm_mic_emulator.sv
// Stereo PDM source: two first-order sigma-delta modulators (left/right)
// sharing one data line, with a self-generated PDM clock. Left bit is driven
// across the high phase of pdm_clk, right bit across the low phase.
// A one-deep pending slot holds the next PCM pair until the next frame boundary.
module pdm_mic_emulator #(
    parameter int W       = 16,
    parameter int CLK_DIV = 4,
    parameter int DECIM   = 64
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_left,
    input  logic [W-1:0] in_right,
    output logic         pdm_clk,
    output logic         pdm_data,
    output logic         frame_start,
    output logic         underrun
);

    localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int BW = (DECIM > 1) ? $clog2(DECIM) : 1;
    localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
    localparam logic [DW-1:0] HALF_CNT = DW'(CLK_DIV / 2);
    localparam logic [BW-1:0] BIT_LAST = BW'(DECIM - 1);
    // Adding 2^(W-1) to a signed sample is just an MSB flip.
    localparam logic [W-1:0]  OFFSET   = {1'b1, {(W-1){1'b0}}};

    logic [DW-1:0] div_cnt_q, div_cnt_d;
    logic [BW-1:0] bit_cnt_q, bit_cnt_d;
    logic          run_q, run_d;
    logic          pend_vld_q, pend_vld_d;
    logic [W-1:0]  pend_l_q, pend_l_d, pend_r_q, pend_r_d;
    logic [W-1:0]  act_l_q, act_l_d, act_r_q, act_r_d;
    logic [W-1:0]  acc_l_q, acc_l_d, acc_r_q, acc_r_d;
    logic          r_bit_q, r_bit_d;
    logic          pdm_clk_q, pdm_clk_d;
    logic          pdm_data_q, pdm_data_d;
    logic          frame_start_q, frame_start_d;
    logic          underrun_q, underrun_d;

    logic          period_start, boundary;
    logic [W-1:0]  act_l_v, act_r_v;
    logic [W:0]    sum_l, sum_r;

    assign in_ready    = !pend_vld_q;
    assign pdm_clk     = pdm_clk_q;
    assign pdm_data    = pdm_data_q;
    assign frame_start = frame_start_q;
    assign underrun    = underrun_q;

    // Next-state: handshake, clock divider, frame boundary and modulators.
    always_comb begin
        div_cnt_d     = div_cnt_q;
        bit_cnt_d     = bit_cnt_q;
        run_d         = run_q;
        pend_vld_d    = pend_vld_q;
        pend_l_d      = pend_l_q;
        pend_r_d      = pend_r_q;
        act_l_d       = act_l_q;
        act_r_d       = act_r_q;
        acc_l_d       = acc_l_q;
        acc_r_d       = acc_r_q;
        r_bit_d       = r_bit_q;
        pdm_clk_d     = pdm_clk_q;
        pdm_data_d    = pdm_data_q;
        frame_start_d = 1'b0;
        underrun_d    = 1'b0;
        act_l_v       = act_l_q;
        act_r_v       = act_r_q;

        // First enabled edge starts a period without waiting for a wrap.
        period_start = en && (!run_q || (div_cnt_q == DIV_LAST));
        boundary     = period_start && (bit_cnt_q == '0);

        // Pending slot fills regardless of en; a same-cycle boundary still
        // sees the slot as empty (no bypass into active).
        if (in_valid && !pend_vld_q) begin
            pend_l_d   = in_left;
            pend_r_d   = in_right;
            pend_vld_d = 1'b1;
        end

        if (boundary) begin
            if (pend_vld_q) begin
                act_l_v    = pend_l_q;
                act_r_v    = pend_r_q;
                pend_vld_d = 1'b0;
            end
        end

        // Bits of the boundary period already use the freshly loaded sample.
        sum_l = {1'b0, acc_l_q} + {1'b0, act_l_v ^ OFFSET};
        sum_r = {1'b0, acc_r_q} + {1'b0, act_r_v ^ OFFSET};

        if (!en) begin
            run_d      = 1'b0;
            div_cnt_d  = '0;
            bit_cnt_d  = '0;
            acc_l_d    = '0;
            acc_r_d    = '0;
            r_bit_d    = 1'b0;
            pdm_clk_d  = 1'b0;
            pdm_data_d = 1'b0;
        end else begin
            run_d = 1'b1;
            if (period_start) begin
                div_cnt_d     = '0;
                bit_cnt_d     = (bit_cnt_q == BIT_LAST) ? '0 : bit_cnt_q + 1'b1;
                frame_start_d = boundary;
                underrun_d    = boundary && !pend_vld_q;
                act_l_d       = act_l_v;
                act_r_d       = act_r_v;
                acc_l_d       = sum_l[W-1:0];
                acc_r_d       = sum_r[W-1:0];
                r_bit_d       = sum_r[W];
                pdm_clk_d     = 1'b1;
                pdm_data_d    = sum_l[W];
            end else begin
                div_cnt_d = div_cnt_q + 1'b1;
                if (div_cnt_d == HALF_CNT) begin
                    pdm_clk_d  = 1'b0;
                    pdm_data_d = r_bit_q;
                end
            end
        end
    end

    // State registers with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_cnt_q     <= '0;
            bit_cnt_q     <= '0;
            run_q         <= 1'b0;
            pend_vld_q    <= 1'b0;
            pend_l_q      <= '0;
            pend_r_q      <= '0;
            act_l_q       <= '0;
            act_r_q       <= '0;
            acc_l_q       <= '0;
            acc_r_q       <= '0;
            r_bit_q       <= 1'b0;
            pdm_clk_q     <= 1'b0;
            pdm_data_q    <= 1'b0;
            frame_start_q <= 1'b0;
            underrun_q    <= 1'b0;
        end else begin
            div_cnt_q     <= div_cnt_d;
            bit_cnt_q     <= bit_cnt_d;
            run_q         <= run_d;
            pend_vld_q    <= pend_vld_d;
            pend_l_q      <= pend_l_d;
            pend_r_q      <= pend_r_d;
            act_l_q       <= act_l_d;
            act_r_q       <= act_r_d;
            acc_l_q       <= acc_l_d;
            acc_r_q       <= acc_r_d;
            r_bit_q       <= r_bit_d;
            pdm_clk_q     <= pdm_clk_d;
            pdm_data_q    <= pdm_data_d;
            frame_start_q <= frame_start_d;
            underrun_q    <= underrun_d;
        end
    end

endmodule

// File: tb/tb_pdm_mic_emulator.sv
// Directed bench for pdm_mic_emulator (W=16, CLK_DIV=4, DECIM=8).
// Inputs change and outputs are sampled on the falling edge of clk.
module tb_pdm_mic_emulator;

    localparam int W = 16;

    logic         clk = 1'b0;
    logic         rst;
    logic         en;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_left;
    logic [W-1:0] in_right;
    logic         pdm_clk;
    logic         pdm_data;
    logic         frame_start;
    logic         underrun;

    int n_tests = 0;
    int n_fail  = 0;

    pdm_mic_emulator #(.W(W), .CLK_DIV(4), .DECIM(8)) dut (
        .clk         (clk),
        .rst         (rst),
        .en          (en),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_left     (in_left),
        .in_right    (in_right),
        .pdm_clk     (pdm_clk),
        .pdm_data    (pdm_data),
        .frame_start (frame_start),
        .underrun    (underrun)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // One PDM period (4 clks): checks clock shape, returns left/right bits
    // and the boundary pulses seen in the first clk. Drops in_valid after P0.
    task automatic get_period(input string tag, output logic l, output logic r,
                              output logic fs, output logic ur);
        @(negedge clk);
        chk({tag, ".clk0"}, pdm_clk, 1'b1);
        l  = pdm_data;
        fs = frame_start;
        ur = underrun;
        in_valid = 1'b0;
        @(negedge clk);
        chk({tag, ".clk1"}, pdm_clk, 1'b1);
        chk({tag, ".fs1"}, frame_start, 1'b0);
        @(negedge clk);
        chk({tag, ".clk2"}, pdm_clk, 1'b0);
        r = pdm_data;
        @(negedge clk);
        chk({tag, ".clk3"}, pdm_clk, 1'b0);
        chk({tag, ".ur3"}, underrun, 1'b0);
    endtask

    // One frame of 8 periods; bit i of exp_l/exp_r is period i.
    // Optionally offers a new pair at the start of period 1.
    task automatic run_frame(input string tag, input logic [7:0] exp_l, input logic [7:0] exp_r,
                             input logic exp_ur, input logic push,
                             input logic [W-1:0] pl, input logic [W-1:0] pr,
                             output logic [7:0] got_l, output logic [7:0] got_r);
        logic l, r, fs, ur;
        for (int i = 0; i < 8; i++) begin
            get_period($sformatf("%s.p%0d", tag, i), l, r, fs, ur);
            got_l[i] = l;
            got_r[i] = r;
            chk($sformatf("%s.fs%0d", tag, i), fs, (i == 0));
            chk($sformatf("%s.ur%0d", tag, i), ur, (i == 0) ? exp_ur : 1'b0);
            if (i == 0 && push) begin
                chk({tag, ".rdy_before_push"}, in_ready, 1'b1);
                in_left  = pl;
                in_right = pr;
                in_valid = 1'b1;
            end
        end
        chk({tag, ".left"}, got_l, exp_l);
        chk({tag, ".right"}, got_r, exp_r);
        if (push) chk({tag, ".rdy_held"}, in_ready, 1'b0);
    endtask

    initial begin
        logic [7:0] gl, gr;
        logic l, r, fs, ur;

        // Reset with random inputs.
        rst      = 1'b1;
        en       = 1'($urandom);
        in_valid = 1'($urandom);
        in_left  = W'($urandom);
        in_right = W'($urandom);
        repeat (3) @(negedge clk);
        chk("rst.pdm_clk", pdm_clk, 1'b0);
        chk("rst.pdm_data", pdm_data, 1'b0);
        chk("rst.in_ready", in_ready, 1'b1);
        chk("rst.frame_start", frame_start, 1'b0);
        chk("rst.underrun", underrun, 1'b0);

        rst = 1'b0; en = 1'b0; in_valid = 1'b0;
        repeat (4) @(negedge clk);
        chk("idle.pdm_clk", pdm_clk, 1'b0);
        chk("idle.pdm_data", pdm_data, 1'b0);
        chk("idle.fs", frame_start, 1'b0);
        chk("idle.in_ready", in_ready, 1'b1);

        // Push midscale pair while disabled; slot fills without en.
        in_left = 16'h0000; in_right = 16'h0000; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        chk("push0.in_ready", in_ready, 1'b0);

        // Frame 0: midscale -> 0,1,0,1...; queue full scale.
        en = 1'b1;
        run_frame("mid", 8'b1010_1010, 8'b1010_1010, 1'b0, 1'b1, 16'h7FFF, 16'h8000, gl, gr);

        // Frame 1: full scale; queue density pair.
        run_frame("full", 8'b1111_1110, 8'b0000_0000, 1'b0, 1'b1, 16'h4000, 16'hC000, gl, gr);
        chk("full.ones_l", $countones(gl), 7);
        chk("full.ones_r", $countones(gr), 0);

        // Disable at a period edge to clear the accumulators, then re-enable.
        en = 1'b0;
        @(negedge clk);
        chk("dis1.pdm_clk", pdm_clk, 1'b0);
        chk("dis1.pdm_data", pdm_data, 1'b0);
        en = 1'b1;

        // Frame 2: density 6/8 left, 2/8 right; nothing queued.
        run_frame("dens", 8'b1110_1110, 8'b1000_1000, 1'b0, 1'b0, '0, '0, gl, gr);
        chk("dens.ones_l", $countones(gl), 6);
        chk("dens.ones_r", $countones(gr), 2);

        // Frame 3: empty slot -> underrun, held sample keeps playing.
        run_frame("urun", 8'b1110_1110, 8'b1000_1000, 1'b1, 1'b0, '0, '0, gl, gr);

        // Offer a pair exactly on the next boundary with the slot empty.
        in_left = 16'h0000; in_right = 16'h0000; in_valid = 1'b1;
        run_frame("bpush", 8'b1110_1110, 8'b1000_1000, 1'b1, 1'b0, '0, '0, gl, gr);
        chk("bpush.in_ready", in_ready, 1'b0);

        // Frame 5: the boundary-pushed midscale pair loads here.
        get_period("f5.p0", l, r, fs, ur);
        chk("f5.fs", fs, 1'b1);
        chk("f5.ur", ur, 1'b0);
        chk("f5.l0", l, 1'b0);
        chk("f5.r0", r, 1'b0);
        chk("f5.in_ready", in_ready, 1'b1);
        @(negedge clk);
        chk("f5.p1.clk", pdm_clk, 1'b1);
        chk("f5.p1.l", pdm_data, 1'b1);
        // Drop en in the high phase with a 1 on the line.
        en = 1'b0;
        @(negedge clk);
        chk("dis2.pdm_clk", pdm_clk, 1'b0);
        chk("dis2.pdm_data", pdm_data, 1'b0);
        repeat (3) @(negedge clk);
        chk("dis2.idle_clk", pdm_clk, 1'b0);

        // Re-enable: restarts like the midscale start (slot empty -> underrun).
        en = 1'b1;
        run_frame("reen", 8'b1010_1010, 8'b1010_1010, 1'b1, 1'b0, '0, '0, gl, gr);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
